// File: rtl/uart_loader.sv
// uart_loader: pairs UART bytes into big-endian words, loads them into program memory
// until 0xFFFF, then forwards run-time words to the CPU; 0xFFFE in run restarts loading.
module uart_loader #(
  parameter int                    ADDR_WIDTH     = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 10'h200,
  parameter logic [ADDR_WIDTH-1:0] LIMIT_ADDR     = 10'h3fe,
  parameter int                    TIMEOUT_CYCLES = 2700000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wr_data,
  output logic                  mem_wr,
  output logic                  load_done,
  output logic [15:0]           uart_word,
  output logic                  uart_word_v,
  output logic [15:0]           word_count,
  output logic                  overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {LOAD, RUN} state_t;
  state_t                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [7:0]            hi_q, hi_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  full_q, full_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]           mem_wr_data_q, mem_wr_data_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [15:0]           uart_word_q, uart_word_d;
  logic                  uart_word_v_q, uart_word_v_d;
  logic [15:0]           word_count_q, word_count_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           w;
  logic                  w_v;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    tcnt_d        = tcnt_q;
    full_d        = full_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_d      = 1'b0;
    uart_word_d   = uart_word_q;
    uart_word_v_d = 1'b0;
    word_count_d  = word_count_q;
    overflow_d    = overflow_q;
    w             = {hi_q, rx_data};
    w_v           = rx_data_wr && phase_q;
    if (rx_data_wr) begin
      phase_d = !phase_q;
      tcnt_d  = '0;
      if (!phase_q) hi_d = rx_data;
    end else if (phase_q) begin
      phase_d = tcnt_q != TW'(TIMEOUT_CYCLES - 1);
      tcnt_d  = phase_d ? tcnt_q + 1'b1 : '0;
    end
    // Pointer advances the cycle after the write; at the limit it parks and marks full.
    if (mem_wr_q) begin
      full_d       = mem_addr_q == LIMIT_ADDR;
      mem_addr_d   = full_d ? mem_addr_q : mem_addr_q + ADDR_WIDTH'(2);
      word_count_d = word_count_q + 16'd1;
    end
    if (w_v && state_q == LOAD) begin
      if (w == 16'hffff) begin
        state_d    = RUN;
        mem_addr_d = BASE_ADDR;
        full_d     = 1'b0;
      end else if (full_q) begin
        overflow_d = 1'b1;
      end else begin
        mem_wr_d      = 1'b1;
        mem_wr_data_d = w;
      end
    end
    if (w_v && state_q == RUN) begin
      if (w == 16'hfffe) begin
        state_d      = LOAD;
        mem_addr_d   = BASE_ADDR;
        full_d       = 1'b0;
        word_count_d = '0;
        overflow_d   = 1'b0;
      end else begin
        uart_word_d   = w;
        uart_word_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      tcnt_q        <= '0;
      full_q        <= 1'b0;
      mem_addr_q    <= BASE_ADDR;
      mem_wr_data_q <= '0;
      mem_wr_q      <= 1'b0;
      uart_word_q   <= '0;
      uart_word_v_q <= 1'b0;
      word_count_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      tcnt_q        <= tcnt_d;
      full_q        <= full_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_q      <= mem_wr_d;
      uart_word_q   <= uart_word_d;
      uart_word_v_q <= uart_word_v_d;
      word_count_q  <= word_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr      = mem_wr_q;
  assign load_done   = state_q == RUN;
  assign uart_word   = uart_word_q;
  assign uart_word_v = uart_word_v_q;
  assign word_count  = word_count_q;
  assign overflow    = overflow_q;
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
Upstream stage of the memory write mux and the CPU reset gate. It turns the UART receiver's byte stream into big-endian 16-bit words and loads them into program memory from BASE_ADDR upward. It detects the 0xFFFF end-of-program marker and then asserts load_done, which releases the CPU. After load, it keeps pairing bytes into run-time input words for the CPU's UART-in register, and accepts a 0xFFFE command to start a new load.

Parameters:
ADDR_WIDTH, 10, memory byte-address width
BASE_ADDR, 10'h200, address of the first loaded word (even)
LIMIT_ADDR, 10'h3fe, last writable word address (even)
TIMEOUT_CYCLES, 2700000, idle cycles after a high byte before the pairing resyncs (100 ms at 27 MHz)

Ports:
sys_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid when rx_data_wr=1
rx_data_wr  in  1  one-cycle strobe per received byte
mem_addr  out  ADDR_WIDTH  write address (even)
mem_wr_data  out  16  write word {high byte, low byte}
mem_wr  out  1  one-cycle word write strobe
load_done  out  1  1 = program loaded; CPU may run
uart_word  out  16  last run-time word
uart_word_v  out  1  one-cycle strobe when uart_word updates
word_count  out  16  words written in the current load
overflow  out  1  sticky: a word arrived after LIMIT_ADDR was written

Behaviour:
- Reset values: mem_addr=BASE_ADDR, mem_wr_data=0, mem_wr=0, load_done=0, uart_word=0, uart_word_v=0, word_count=0, overflow=0, state=LOAD, phase=HI, timeout counter=0.
- Reset is asynchronous and can occur mid-operation. Any partial word is discarded.
- Pairing, in both states:
  - A byte with phase=HI latches hi_byte and sets phase=LO.
  - A byte with phase=LO forms W={hi_byte, rx_data} and sets phase=HI.
- Timeout:
  - The counter runs only while phase=LO and is cleared by every rx_data_wr.
  - When it reaches TIMEOUT_CYCLES-1 with no byte that cycle, phase returns to HI and hi_byte is dropped.
  - If a byte arrives in the same cycle as expiry, the byte wins and is taken as the low byte.
- State LOAD (load_done=0):
  - If W==16'hFFFF, go to RUN. load_done=1 from the next cycle. mem_addr returns to BASE_ADDR. No write.
  - Any other W with write pointer ≤ LIMIT_ADDR:
    - Next cycle: mem_wr=1, with mem_addr=pointer and mem_wr_data=W both valid in that cycle.
    - Cycle after: pointer +=2, word_count +=1.
    - Latency from the low-byte strobe to mem_wr is 1 cycle.
  - Any other W with pointer past LIMIT_ADDR (all words already written): word dropped, overflow=1. The pointer does not wrap.
  - Since words need at least 2 strobes, a new W cannot form while mem_wr is high.
- State RUN (load_done=1):
  - W==16'hFFFE starts a reload:
    - Next cycle: load_done=0, state=LOAD.
    - pointer=BASE_ADDR, word_count=0, overflow=0.
    - uart_word is not updated.
  - Any other W (including 0xFFFF):
    - Next cycle: uart_word=W, uart_word_v=1 for exactly 1 cycle.
  - mem_wr is never asserted in RUN.
- uart_word holds its value until the next run-time word or reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then bytes 12 34 AB CD FF FF → mem_wr pulses with (0x200, 0x1234) then (0x202, 0xABCD); load_done rises 1 cycle after the last FF; word_count=2.
- After load, bytes 00 41 → uart_word=0x0041, uart_word_v high for 1 cycle; no mem_wr; load_done stays 1.
- Byte 55, idle TIMEOUT_CYCLES, then bytes 12 34 FF FF → single write (0x200, 0x1234). The 55 is discarded.
- Byte 55, then byte 66 arriving exactly on the timeout expiry cycle → write (0x200, 0x5566).
- Load 257 words into a 0x200..0x3fe window, then FF FF → 256 writes, last at 0x3fe; overflow=1; word_count=256; load_done=1.
- In RUN, bytes FF FE → load_done=0 next cycle, overflow/word_count cleared; then 00 01 FF FF → write (0x200, 0x0001), load_done=1.
- Deassert rst_n between a high byte and a low byte → all outputs at reset values; the next two bytes pair as a fresh word.
